hazard_fwd_ctrl: RTL and testbench
==================================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage ARM pipeline (IF, ID/RF, EX, MEM, WB).
//  Tracks destination registers of in-flight instructions in a 3-entry scoreboard (EX/MEM/WB).
//  Generates stall/bubble/flush controls for the IF/ID and regfileread queue registers.
//  Produces registered operand forwarding selects that arrive aligned with the instruction entering EX.
// PARAMETERS
//  ADDR_W     5   register address width
//  ZERO_REG   31  register index hardwired to zero; never creates a hazard
//  FLUSH_LEN  1   cycles of flush/bubble per taken branch (1..4)
// PORTS
//  clk       in   1       clock, all state updates on posedge
//  reset     in   1       synchronous, active-low; reset==0 at posedge resets all state
//  IdValid   in   1       instruction in ID/RF is valid
//  IdRn      in   ADDR_W  first source register
//  IdRm      in   ADDR_W  second source register
//  IdRd      in   ADDR_W  destination register
//  IdUseRn   in   1       instruction reads Rn
//  IdUseRm   in   1       instruction reads Rm
//  IdWrRd    in   1       instruction writes Rd
//  IdLoad    in   1       instruction is a load (LDUR)
//  BrTaken   in   1       branch in EX resolved taken this cycle
//  Stall     out  1       hold PC and IF/ID register
//  Bubble    out  1       regfileread queue captures NOP (all controls 0) instead of ID
//  Flush     out  1       clear IF/ID register
//  FwdA      out  2       operand A select in EX: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB data
//  FwdB      out  2       operand B select, same encoding
// BEHAVIOUR
//  Reset: FSM=RUN, flush counter=0, all scoreboard entries invalid, FwdA=FwdB=00.
//   Stall/Bubble/Flush=0 while reset==0.
//  Scoreboard entry = {valid, rd, wr, load}; a match requires valid & wr & rd==src & src!=ZERO_REG & use bit.
//  Scoreboard shift each posedge: WB<=MEM, MEM<=EX, EX<=(Bubble ? invalid : ID entry gated by IdValid).
//  FSM states:
//   RUN: if BrTaken -> Flush=Bubble=1, Stall=0; go FLUSH if FLUSH_LEN>1 (cnt=FLUSH_LEN-1), else stay RUN.
//    Else if load-use (EX entry load & match on Rn or Rm) -> Stall=Bubble=1, go STALL.
//    Else all 0.
//   STALL: Stall=0, Bubble=0, load-use detection suppressed, BrTaken still honoured as in RUN.
//    Next state RUN, unless a branch takes it to FLUSH.
//   FLUSH: Flush=Bubble=1, Stall=0; cnt decrements; RUN when cnt reaches 1. BrTaken here reloads cnt.
//  Priority: BrTaken over load-use. A branch in the same cycle as a load-use hazard flushes, no stall.
//  Forwarding select computed per source at ID and registered at posedge.
//   Priority EX match -> 01, MEM match -> 10, WB match -> 11, else 00.
//   The instruction reaches EX one cycle later, so select aligns with that cycle.
//   Load in EX slot never yields 01; a stall results instead, then 10 after the stall.
//   When Bubble=1, next FwdA/FwdB = 00.
//  Latency: Stall/Bubble/Flush combinational from state + inputs. FwdA/FwdB 1 cycle.
//  Reset mid-operation: scoreboard cleared in the same posedge; no residual stall/flush next cycle.
// TESTING
//  1 Reset: reset=0 two cycles with IdValid=1 writing X1 -> Stall/Bubble/Flush=0, FwdA/B=00.
//    Scoreboard empty after release.
//  2 EX fwd: ADD X1 then ADD X2,X1,X3 back-to-back -> second sees FwdA=01, FwdB=00, no stall.
//  3 MEM/WB fwd: producer X4, one unrelated instr, consumer reads X4 -> FwdA=10.
//    Two unrelated instrs in between -> FwdA=11.
//  4 Load-use: LDUR X5, then ADD X6,X5,X5 -> 1 cycle Stall=Bubble=1.
//    Consumer then gets FwdA=FwdB=10. Exactly one stall.
//  5 Branch: BrTaken=1 with FLUSH_LEN=2 -> Flush=Bubble=1 for 2 cycles, then RUN.
//    Same cycle as a load-use hazard -> Flush only, Stall=0.
//  6 Zero/mid-reset: producer writing X31 -> never forwards/stalls.
//    reset=0 during STALL -> next cycle RUN, all outputs 0.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: hazard and forwarding controller for a 5-stage pipeline.
// A 3-entry scoreboard (EX/MEM/WB) holds the destination registers of
// in-flight instructions. Stall/Bubble/Flush are combinational from the
// FSM state and the current inputs. Operand forwarding selects are computed
// from the instruction in ID and registered, so they line up with the cycle
// in which that instruction occupies EX.
module hazard_fwd_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int ZERO_REG  = 31,
  parameter int FLUSH_LEN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IdValid,
  input  logic [ADDR_W-1:0] IdRn,
  input  logic [ADDR_W-1:0] IdRm,
  input  logic [ADDR_W-1:0] IdRd,
  input  logic              IdUseRn,
  input  logic              IdUseRm,
  input  logic              IdWrRd,
  input  logic              IdLoad,
  input  logic              BrTaken,
  output logic              Stall,
  output logic              Bubble,
  output logic              Flush,
  output logic [1:0]        FwdA,
  output logic [1:0]        FwdB
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam int                CNT_W     = 3;
  // Cycles spent in FLUSH after the cycle in which the branch was seen.
  localparam logic [CNT_W-1:0]  FLUSH_RELOAD = CNT_W'(FLUSH_LEN - 1);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [1:0] SEL_WB    = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Scoreboard payload; the valid bit is kept separately so that only the
  // control bit needs a reset.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic              wr;
    logic              load;
  } sb_pl_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic   ex_vld_q, mem_vld_q, wb_vld_q;
  logic   ex_vld_d;
  sb_pl_t ex_pl_q, mem_pl_q, wb_pl_q;
  sb_pl_t id_pl;

  logic [1:0] fwd_a_q, fwd_b_q;
  logic [1:0] fwd_a_d, fwd_b_d;

  logic load_use;
  logic stall_c, bubble_c, flush_c;

  // True when a scoreboard entry produces the register a source reads.
  function automatic logic src_match(
    input logic              vld,
    input sb_pl_t            pl,
    input logic [ADDR_W-1:0] src,
    input logic              use_src
  );
    src_match = vld & pl.wr & use_src & (pl.rd == src) & (src != ZERO_ADDR);
  endfunction

  // Youngest producer wins. A load sitting in EX cannot supply data yet,
  // so it is skipped here; the load-use stall covers that case.
  function automatic logic [1:0] fwd_select(
    input logic              ex_vld,
    input sb_pl_t            ex_pl,
    input logic              mem_vld,
    input sb_pl_t            mem_pl,
    input logic              wb_vld,
    input sb_pl_t            wb_pl,
    input logic [ADDR_W-1:0] src,
    input logic              use_src
  );
    if (src_match(ex_vld, ex_pl, src, use_src) && !ex_pl.load) begin
      fwd_select = SEL_EXMEM;
    end else if (src_match(mem_vld, mem_pl, src, use_src)) begin
      fwd_select = SEL_MEMWB;
    end else if (src_match(wb_vld, wb_pl, src, use_src)) begin
      fwd_select = SEL_WB;
    end else begin
      fwd_select = SEL_RF;
    end
  endfunction

  // ID entry that would enter EX, and the load-use hazard against EX.
  always_comb begin
    id_pl      = '0;
    id_pl.rd   = IdRd;
    id_pl.wr   = IdWrRd;
    id_pl.load = IdLoad;
    load_use   = ex_vld_q & ex_pl_q.load &
                 (src_match(ex_vld_q, ex_pl_q, IdRn, IdUseRn) |
                  src_match(ex_vld_q, ex_pl_q, IdRm, IdUseRm));
  end

  // Control FSM: next state, flush counter and the stall/bubble/flush strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (BrTaken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (FLUSH_LEN > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (load_use) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = ST_STALL;
        end
      end
      ST_STALL: begin
        // The load has moved to MEM; its consumer now forwards instead.
        state_d = ST_RUN;
        if (BrTaken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (FLUSH_LEN > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end
      end
      ST_FLUSH: begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        if (BrTaken) begin
          cnt_d = FLUSH_RELOAD;
        end else if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
    // No strobes are asserted while reset is held.
    if (!reset) begin
      stall_c  = 1'b0;
      bubble_c = 1'b0;
      flush_c  = 1'b0;
    end
  end

  // Next forwarding selects and the valid bit entering the EX slot.
  always_comb begin
    fwd_a_d  = SEL_RF;
    fwd_b_d  = SEL_RF;
    ex_vld_d = 1'b0;
    if (!bubble_c) begin
      fwd_a_d  = fwd_select(ex_vld_q, ex_pl_q, mem_vld_q, mem_pl_q,
                            wb_vld_q, wb_pl_q, IdRn, IdUseRn);
      fwd_b_d  = fwd_select(ex_vld_q, ex_pl_q, mem_vld_q, mem_pl_q,
                            wb_vld_q, wb_pl_q, IdRm, IdUseRm);
      ex_vld_d = IdValid;
    end
  end

  // FSM state and flush counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scoreboard valid bits shift EX -> MEM -> WB.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_vld_q  <= 1'b0;
      mem_vld_q <= 1'b0;
      wb_vld_q  <= 1'b0;
    end else begin
      ex_vld_q  <= ex_vld_d;
      mem_vld_q <= ex_vld_q;
      wb_vld_q  <= mem_vld_q;
    end
  end

  // Scoreboard payload shifts alongside; meaningless while valid is low.
  always_ff @(posedge clk) begin
    ex_pl_q  <= id_pl;
    mem_pl_q <= ex_pl_q;
    wb_pl_q  <= mem_pl_q;
  end

  // Registered forwarding selects, aligned with the instruction in EX.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign Stall  = stall_c;
  assign Bubble = bubble_c;
  assign Flush  = flush_c;
  assign FwdA   = fwd_a_q;
  assign FwdB   = fwd_b_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Testbench for hazard_fwd_ctrl: directed scenarios followed by random
// traffic, all checked every cycle against a behavioural pipeline model.
module tb_hazard_fwd_ctrl;

  localparam int AW = 5;
  localparam int FL = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          IdValid;
  logic [AW-1:0] IdRn, IdRm, IdRd;
  logic          IdUseRn, IdUseRm, IdWrRd, IdLoad, BrTaken;
  logic          Stall, Bubble, Flush;
  logic [1:0]    FwdA, FwdB;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.ADDR_W(AW), .ZERO_REG(31), .FLUSH_LEN(FL)) dut (
    .clk(clk), .reset(reset), .IdValid(IdValid),
    .IdRn(IdRn), .IdRm(IdRm), .IdRd(IdRd),
    .IdUseRn(IdUseRn), .IdUseRm(IdUseRm), .IdWrRd(IdWrRd), .IdLoad(IdLoad),
    .BrTaken(BrTaken),
    .Stall(Stall), .Bubble(Bubble), .Flush(Flush),
    .FwdA(FwdA), .FwdB(FwdB)
  );

  int checks = 0;
  int errors = 0;

  // Model: the three instructions past ID (index 0 = EX, 1 = MEM, 2 = WB),
  // the number of forced flush cycles still owed, and whether the previous
  // cycle was a load-use stall.
  typedef struct packed {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } minstr_t;

  minstr_t pipe [3];
  int      flush_left   = 0;
  bit      just_stalled = 1'b0;
  int      exp_fa = 0, exp_fb = 0;
  bit      fwd_known = 1'b0;
  logic    obs_stall, obs_bubble, obs_flush;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input int k, input int src, input bit use_src);
    return pipe[k].v && pipe[k].wr && use_src && (pipe[k].rd == src) && (src != 31);
  endfunction

  // Nearest older producer supplies the operand; a load still in EX cannot.
  function automatic int model_fwd(input int src, input bit use_src);
    for (int k = 0; k < 3; k++) begin
      if (hit(k, src, use_src) && !(k == 0 && pipe[0].ld)) return k + 1;
    end
    return 0;
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cycle(input bit rst_n, input bit v, input int rn, input int rm,
                       input int rd, input bit urn, input bit urm, input bit wr,
                       input bit ld, input bit br);
    bit es, eb, ef, lu;
    int nfa, nfb;
    reset   = rst_n;
    IdValid = v;
    IdRn    = AW'(rn);
    IdRm    = AW'(rm);
    IdRd    = AW'(rd);
    IdUseRn = urn;
    IdUseRm = urm;
    IdWrRd  = wr;
    IdLoad  = ld;
    BrTaken = br;
    #2;
    es = 1'b0; eb = 1'b0; ef = 1'b0;
    if (rst_n) begin
      lu = !just_stalled && (flush_left == 0) && pipe[0].ld &&
           (hit(0, rn, urn) || hit(0, rm, urm));
      if (br || flush_left > 0) begin
        ef = 1'b1; eb = 1'b1;
      end else if (lu) begin
        es = 1'b1; eb = 1'b1;
      end
    end
    obs_stall  = Stall;
    obs_bubble = Bubble;
    obs_flush  = Flush;
    chk("stall",  {1'b0, Stall},  {1'b0, es});
    chk("bubble", {1'b0, Bubble}, {1'b0, eb});
    chk("flush",  {1'b0, Flush},  {1'b0, ef});
    if (fwd_known) begin
      chk("fwdA", FwdA, 2'(exp_fa));
      chk("fwdB", FwdB, 2'(exp_fb));
    end
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) pipe[k] = '0;
      flush_left   = 0;
      just_stalled = 1'b0;
      exp_fa       = 0;
      exp_fb       = 0;
      fwd_known    = 1'b1;
    end else begin
      nfa = eb ? 0 : model_fwd(rn, urn);
      nfb = eb ? 0 : model_fwd(rm, urm);
      if (br) flush_left = FL - 1;
      else if (flush_left > 0) flush_left--;
      just_stalled = es;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = '{v: (eb ? 1'b0 : v), rd: rd, wr: wr, ld: ld};
      exp_fa = nfa;
      exp_fb = nfb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input int rd, input int rn, input int rm);
    cycle(1'b1, 1'b1, rn, rm, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic ldur(input int rd, input int rn);
    cycle(1'b1, 1'b1, rn, 0, rd, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  function automatic int rreg();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 31 : r;
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) pipe[k] = '0;

    // Reset held two cycles while ID writes X1.
    cycle(1'b0, 1'b1, 0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_fwdA", FwdA, 2'b00);
    chk("rst_fwdB", FwdB, 2'b00);
    alu(2, 1, 1);
    chk("rst_sb_empty", FwdA, 2'b00);

    // Back-to-back EX forwarding.
    alu(1, 5, 6);
    alu(2, 1, 3);
    chk("ex_nostall", {1'b0, obs_stall}, 2'b00);
    chk("ex_fwdA", FwdA, 2'b01);
    chk("ex_fwdB", FwdB, 2'b00);

    // MEM and WB forwarding.
    alu(4, 0, 0);
    alu(8, 0, 0);
    alu(9, 4, 0);
    chk("mem_fwdA", FwdA, 2'b10);
    alu(4, 0, 0);
    alu(8, 0, 0);
    alu(10, 0, 0);
    alu(11, 4, 0);
    chk("wb_fwdA", FwdA, 2'b11);

    // Load-use: exactly one stall, then MEM forwarding.
    ldur(5, 0);
    alu(6, 5, 5);
    chk("lu_stall",  {1'b0, obs_stall},  2'b01);
    chk("lu_bubble", {1'b0, obs_bubble}, 2'b01);
    alu(6, 5, 5);
    chk("lu_once", {1'b0, obs_stall}, 2'b00);
    chk("lu_fwdA", FwdA, 2'b10);
    chk("lu_fwdB", FwdB, 2'b10);
    idle();

    // Taken branch: two flush cycles, then back to normal.
    cycle(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("br_flush0", {1'b0, obs_flush}, 2'b01);
    idle();
    chk("br_flush1", {1'b0, obs_flush}, 2'b01);
    idle();
    chk("br_done", {1'b0, obs_flush}, 2'b00);
    // Branch coinciding with a load-use hazard.
    ldur(7, 0);
    cycle(1'b1, 1'b1, 7, 7, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("br_lu_flush", {1'b0, obs_flush}, 2'b01);
    chk("br_lu_nostall", {1'b0, obs_stall}, 2'b00);
    idle();
    idle();

    // Zero register never forwards or stalls.
    alu(31, 0, 0);
    alu(12, 31, 31);
    chk("zr_fwdA", FwdA, 2'b00);
    chk("zr_fwdB", FwdB, 2'b00);
    ldur(31, 0);
    alu(13, 31, 31);
    chk("zr_nostall", {1'b0, obs_stall}, 2'b00);

    // Reset asserted during the stall cycle.
    idle();
    ldur(14, 0);
    alu(15, 14, 14);
    chk("mr_stall", {1'b0, obs_stall}, 2'b01);
    cycle(1'b0, 1'b1, 14, 14, 15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    alu(15, 14, 14);
    chk("mr_nostall", {1'b0, obs_stall}, 2'b00);
    chk("mr_noflush", {1'b0, obs_flush}, 2'b00);
    chk("mr_fwdA", FwdA, 2'b00);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
            rreg(), rreg(), rreg(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
